// File: rtl/fc_param_streamer.sv
// Weight/bias store for the FC layer: streams one neuron's N_IN weights then its bias
// over a valid/ready port, and accepts run-time parameter loads while idle.
module fc_param_streamer #(
  parameter int    N_IN      = 8,
  parameter int    N_OUT     = 4,
  parameter int    W_W       = 8,
  parameter int    B_W       = 16,
  parameter string INIT_FILE = "",
  localparam int   NW        = (N_OUT > 1) ? $clog2(N_OUT) : 1,
  localparam int   IW        = (N_IN > 1) ? $clog2(N_IN) : 1,
  localparam int   DEPTH     = N_OUT * (N_IN + 1),
  localparam int   AW        = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [NW-1:0]         neuron_idx,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic signed [W_W-1:0] out_weight,
  output logic signed [B_W-1:0] out_bias,
  output logic                  out_is_bias,
  output logic [IW-1:0]         out_idx,
  input  logic                  ld_en,
  input  logic [AW-1:0]         ld_addr,
  input  logic [B_W-1:0]        ld_data
);

  localparam int              KW      = $clog2(N_IN + 1);
  localparam logic [KW-1:0]   K_BIAS  = KW'(N_IN);
  localparam logic [NW:0]     N_OUT_X = (NW + 1)'(N_OUT);
  localparam logic [AW:0]     DEPTH_X = (AW + 1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, PRIME, STREAM} state_t;

  state_t               state;
  logic [KW-1:0]        k;
  logic [NW-1:0]        nsel;
  logic [AW-1:0]        rd_addr;
  logic [B_W-1:0]       rd_word;
  logic                 idle, idx_ok, addr_ok, wr_en;
  logic                 beat_is_bias;
  logic signed [W_W-1:0] beat_weight;
  logic signed [B_W-1:0] beat_bias;
  logic [IW-1:0]        beat_idx;

  logic [B_W-1:0] mem [DEPTH];

  initial begin
    for (int unsigned a = 0; a < DEPTH; a++) mem[a] = (a < N_OUT * N_IN) ? B_W'(1) : '0;
  end

  assign idle    = (state == IDLE);
  assign idx_ok  = ({1'b0, neuron_idx} < N_OUT_X);
  assign addr_ok = ({1'b0, ld_addr} < DEPTH_X);
  assign wr_en   = ld_en && idle && addr_ok;

  always_ff @(posedge clk) begin
    if (wr_en) mem[ld_addr] <= ld_data;
  end

  // k names the beat to fetch next; the read lands straight in the output registers
  always_comb begin
    rd_addr = '0;
    if (k < K_BIAS) rd_addr = AW'(nsel) * AW'(N_IN) + AW'(k);
    else            rd_addr = AW'(N_OUT * N_IN) + AW'(nsel);
    rd_word      = mem[rd_addr];
    beat_is_bias = (k == K_BIAS);
    beat_weight  = beat_is_bias ? '0 : rd_word[W_W-1:0];
    beat_bias    = beat_is_bias ? rd_word : '0;
    beat_idx     = beat_is_bias ? '0 : IW'(k);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      k           <= '0;
      nsel        <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      out_valid   <= 1'b0;
      out_is_bias <= 1'b0;
      out_weight  <= '0;
      out_bias    <= '0;
      out_idx     <= '0;
    end else begin
      done <= 1'b0;
      err  <= ld_en && !(idle && addr_ok);
      case (state)
        IDLE: begin
          if (start) begin
            if (idx_ok) begin
              state <= PRIME;
              busy  <= 1'b1;
              nsel  <= neuron_idx;
              k     <= '0;
            end else begin
              err <= 1'b1;
            end
          end
        end
        PRIME: begin
          out_valid   <= 1'b1;
          out_weight  <= beat_weight;
          out_bias    <= beat_bias;
          out_is_bias <= beat_is_bias;
          out_idx     <= beat_idx;
          k           <= k + KW'(1);
          state       <= STREAM;
        end
        STREAM: begin
          if (out_ready) begin
            if (out_is_bias) begin
              out_valid   <= 1'b0;
              out_is_bias <= 1'b0;
              out_bias    <= '0;
              busy        <= 1'b0;
              done        <= 1'b1;
              state       <= IDLE;
            end else begin
              out_weight  <= beat_weight;
              out_bias    <= beat_bias;
              out_is_bias <= beat_is_bias;
              out_idx     <= beat_idx;
              k           <= k + KW'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fc_param_streamer.sv
// Scoreboard bench for fc_param_streamer: stimulus pushes expected beats from a
// parameter-array model, a negedge monitor pops and compares accepted beats.
module tb_fc_param_streamer;
  localparam int N_IN = 8, N_OUT = 4, W_W = 8, B_W = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, start, busy, done, err, out_valid, out_ready, out_is_bias, ld_en;
  logic [1:0] neuron_idx;
  logic signed [W_W-1:0] out_weight;
  logic signed [B_W-1:0] out_bias;
  logic [2:0] out_idx;
  logic [5:0] ld_addr;
  logic [B_W-1:0] ld_data;

  fc_param_streamer #(.N_IN(N_IN), .N_OUT(N_OUT), .W_W(W_W), .B_W(B_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .neuron_idx(neuron_idx),
    .busy(busy), .done(done), .err(err), .out_valid(out_valid), .out_ready(out_ready),
    .out_weight(out_weight), .out_bias(out_bias), .out_is_bias(out_is_bias), .out_idx(out_idx),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data));

  // Small instance with a non-power-of-two neuron count so an out-of-range index is encodable
  logic s3_start, s3_busy, s3_done, s3_err, s3_valid, s3_is_bias;
  logic s3_ready = 1'b1, s3_ld_en = 1'b0;
  logic [1:0] s3_idx;
  logic signed [7:0] s3_weight;
  logic signed [15:0] s3_bias;
  logic [0:0] s3_out_idx;
  logic [3:0] s3_ld_addr = '0;
  logic [15:0] s3_ld_data = '0;

  fc_param_streamer #(.N_IN(2), .N_OUT(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(s3_start), .neuron_idx(s3_idx),
    .busy(s3_busy), .done(s3_done), .err(s3_err), .out_valid(s3_valid), .out_ready(s3_ready),
    .out_weight(s3_weight), .out_bias(s3_bias), .out_is_bias(s3_is_bias), .out_idx(s3_out_idx),
    .ld_en(s3_ld_en), .ld_addr(s3_ld_addr), .ld_data(s3_ld_data));

  typedef struct {
    logic is_bias;
    logic signed [7:0] w;
    logic signed [15:0] b;
    int idx;
  } beat_t;

  beat_t exp_q[$];
  logic signed [7:0]  mw [N_OUT][N_IN];
  logic signed [15:0] mb [N_OUT];
  int total = 0, bad = 0, accepted = 0;
  bit rand_ready = 1'b0;

  task automatic chk(input string name, input logic signed [31:0] act, input logic signed [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
    end
  endtask

  task automatic push_stream(input int n);
    beat_t e;
    for (int i = 0; i < N_IN; i++) begin
      e.is_bias = 1'b0; e.w = mw[n][i]; e.b = '0; e.idx = i;
      exp_q.push_back(e);
    end
    e.is_bias = 1'b1; e.w = '0; e.b = mb[n]; e.idx = 0;
    exp_q.push_back(e);
  endtask

  task automatic model_write(input int addr, input logic [15:0] data);
    if (addr < N_OUT * N_IN) mw[addr / N_IN][addr % N_IN] = data[7:0];
    else mb[addr - N_OUT * N_IN] = data;
  endtask

  task automatic start_stream(input int n);
    logic [31:0] nv;
    nv = n;
    push_stream(n);
    start = 1'b1; neuron_idx = nv[1:0];
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic load(input int addr, input logic [15:0] data, input bit ok);
    logic [31:0] av;
    av = addr;
    ld_en = 1'b1; ld_addr = av[5:0]; ld_data = data;
    @(posedge clk); #1;
    ld_en = 1'b0;
    chk("ld_err", err, !ok);
    if (ok) model_write(addr, data);
  endtask

  task automatic wait_done(input int c0, output int cyc);
    cyc = c0;
    while (!done && cyc < 300) begin
      @(posedge clk); #1;
      cyc++;
    end
    if (!done) begin
      total++; bad++;
      $display("FAIL done_timeout: got no done expected done within 300 cycles");
    end
  endtask

  // Monitor: compares accepted beats against the queue, checks hold under stall and done timing
  initial begin : monitor
    bit held_v = 1'b0, done_exp = 1'b0;
    beat_t held, e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        held_v = 1'b0; done_exp = 1'b0;
      end else begin
        chk("done_pulse", done, done_exp);
        done_exp = 1'b0;
        if (held_v) begin
          chk("hold_valid", out_valid, 1);
          chk("hold_weight", out_weight, held.w);
          chk("hold_bias", out_bias, held.b);
          chk("hold_is_bias", out_is_bias, held.is_bias);
          chk("hold_idx", out_idx, held.idx);
        end
        held_v = 1'b0;
        if (out_valid) begin
          if (out_ready) begin
            accepted++;
            if (exp_q.size() == 0) begin
              total++; bad++;
              $display("FAIL unexpected_beat: got beat idx=%0d expected none", out_idx);
            end else begin
              e = exp_q.pop_front();
              chk("beat_is_bias", out_is_bias, e.is_bias);
              chk("beat_weight", out_weight, e.w);
              chk("beat_bias", out_bias, e.b);
              chk("beat_idx", out_idx, e.idx);
              if (e.is_bias) done_exp = 1'b1;
            end
          end else begin
            held_v = 1'b1;
            held.w = out_weight; held.b = out_bias; held.is_bias = out_is_bias; held.idx = out_idx;
          end
        end
      end
    end
  end

  initial begin : ready_drv
    out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      out_ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int cyc, a;
    bit found;
    logic [15:0] d;
    for (int j = 0; j < N_OUT; j++) begin
      for (int i = 0; i < N_IN; i++) mw[j][i] = 8'sd1;
      mb[j] = '0;
    end
    rst_n = 1'b0; start = 1'b0; neuron_idx = '0; ld_en = 1'b0; ld_addr = '0; ld_data = '0;
    s3_start = 1'b0; s3_idx = '0;
    #12;
    chk("rst_busy", busy, 0); chk("rst_done", done, 0); chk("rst_err", err, 0);
    chk("rst_valid", out_valid, 0); chk("rst_is_bias", out_is_bias, 0);
    chk("rst_weight", out_weight, 0); chk("rst_bias", out_bias, 0); chk("rst_idx", out_idx, 0);
    @(posedge clk); #1; rst_n = 1'b1;
    @(posedge clk); #1;

    // default contents, neuron 2, latency
    accepted = 0;
    start_stream(2);
    chk("c1_valid", out_valid, 0); chk("c1_busy", busy, 1);
    @(posedge clk); #1;
    chk("c2_valid", out_valid, 1);
    wait_done(2, cyc);
    chk("start_to_done", cyc, 11);
    chk("busy_after_done", busy, 0);
    chk("beats_t1", accepted, 9);

    // signed loads into neuron 1
    for (int i = 0; i < N_IN; i++) load(N_IN + i, 16'(i - 4), 1'b1);
    load(N_OUT * N_IN + 1, 16'hFED4, 1'b1);
    accepted = 0;
    start_stream(1);
    wait_done(1, cyc);
    chk("beats_t2", accepted, 9);

    // random stalls
    rand_ready = 1'b1; accepted = 0;
    start_stream(1);
    wait_done(1, cyc);
    chk("beats_t3", accepted, 9);
    rand_ready = 1'b0;
    @(posedge clk); #1;

    // rejected requests
    load(36, 16'h1234, 1'b0);
    chk("no_stream_valid", out_valid, 0); chk("no_stream_busy", busy, 0);
    accepted = 0;
    start_stream(0);
    load(5, 16'h0055, 1'b0);
    start = 1'b1; neuron_idx = 2'd3;
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_start_err", err, 0); chk("busy_start_busy", busy, 1);
    wait_done(0, cyc);
    chk("beats_t4", accepted, 9);
    s3_start = 1'b1; s3_idx = 2'd3;
    @(posedge clk); #1;
    s3_start = 1'b0;
    chk("s3_idx_err", s3_err, 1); chk("s3_idx_busy", s3_busy, 0);
    @(posedge clk); #1;
    chk("s3_err_pulse", s3_err, 0); chk("s3_no_valid", s3_valid, 0);
    s3_start = 1'b1; s3_idx = 2'd2;
    @(posedge clk); #1;
    s3_start = 1'b0;
    @(posedge clk); #1;
    chk("s3_b0_w", s3_weight, 1); chk("s3_b0_idx", s3_out_idx, 0); chk("s3_b0_v", s3_valid, 1);
    @(posedge clk); #1;
    chk("s3_b1_w", s3_weight, 1); chk("s3_b1_idx", s3_out_idx, 1);
    @(posedge clk); #1;
    chk("s3_b2_bias", s3_is_bias, 1); chk("s3_b2_b", s3_bias, 0); chk("s3_b2_w", s3_weight, 0);
    @(posedge clk); #1;
    chk("s3_done", s3_done, 1); chk("s3_end_valid", s3_valid, 0);

    // reset mid-stream, then restart
    start_stream(2);
    found = 1'b0;
    for (int c = 0; c < 40 && !found; c++) begin
      @(negedge clk);
      if (out_valid && out_idx == 3'd5) found = 1'b1;
    end
    if (!found) begin
      total++; bad++;
      $display("FAIL beat5_timeout: got no beat 5 expected beat 5 within 40 cycles");
    end
    #2 rst_n = 1'b0;
    #1;
    chk("amid_valid", out_valid, 0); chk("amid_busy", busy, 0); chk("amid_weight", out_weight, 0);
    chk("amid_idx", out_idx, 0); chk("amid_done", done, 0);
    exp_q.delete();
    @(posedge clk); #1;
    chk("rst_hold_done", done, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    accepted = 0;
    start_stream(2);
    wait_done(1, cyc);
    chk("beats_t5", accepted, 9);

    // same-cycle start and load
    model_write(0, 16'h007F);
    push_stream(0);
    start = 1'b1; neuron_idx = 2'd0; ld_en = 1'b1; ld_addr = 6'd0; ld_data = 16'h007F;
    @(posedge clk); #1;
    start = 1'b0; ld_en = 1'b0;
    chk("same_cycle_err", err, 0);
    wait_done(1, cyc);

    // randomized loads and streams
    for (int r = 0; r < 8; r++) begin
      for (int l = 0; l < 4; l++) begin
        a = $urandom_range(0, 47);
        d = 16'($urandom);
        load(a, d, a < 36);
      end
      rand_ready = $urandom_range(0, 1);
      accepted = 0;
      start_stream($urandom_range(0, N_OUT - 1));
      wait_done(1, cyc);
      chk("beats_rand", accepted, 9);
      rand_ready = 1'b0;
      @(posedge clk); #1;
    end

    @(negedge clk);
    chk("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
